guard_reset_sequencer: RTL and testbench

GUARD_RESET_SEQUENCER -- requirements
Module: guard_reset_sequencer

---
 rtl/guard_reset_sequencer_if.sv | 36 +++
 rtl/guard_reset_sequencer.sv | 125 ++++++++++++
 tb/tb_guard_reset_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/guard_reset_sequencer_if.sv
// Control and status bundle between the guard reset sequencer and its
// environment (read/write guards, AXI isolation stage, interrupt logic).
//   enable_i, rd_reset_req_i, wr_reset_req_i, isolated_i, irq_clr_i : to sequencer
//   isolate_o, slv_rst_o, reset_clear_o, busy_o, irq_o,
//   cause_o[1:0], drain_timeout_o, reset_count_o[CntWidth-1:0]     : from sequencer
interface guard_reset_sequencer_if #(
  parameter int CntWidth = 8
);
  logic                enable_i;
  logic                rd_reset_req_i;
  logic                wr_reset_req_i;
  logic                isolated_i;
  logic                irq_clr_i;
  logic                isolate_o;
  logic                slv_rst_o;
  logic                reset_clear_o;
  logic                busy_o;
  logic                irq_o;
  logic [1:0]          cause_o;
  logic                drain_timeout_o;
  logic [CntWidth-1:0] reset_count_o;

  // Sequencer side.
  modport slave (
    input  enable_i, rd_reset_req_i, wr_reset_req_i, isolated_i, irq_clr_i,
    output isolate_o, slv_rst_o, reset_clear_o, busy_o, irq_o,
           cause_o, drain_timeout_o, reset_count_o
  );

  // Environment side.
  modport master (
    output enable_i, rd_reset_req_i, wr_reset_req_i, isolated_i, irq_clr_i,
    input  isolate_o, slv_rst_o, reset_clear_o, busy_o, irq_o,
           cause_o, drain_timeout_o, reset_count_o
  );
endinterface

// File: rtl/guard_reset_sequencer.sv
// Guard reset sequencer: on a reset request from the read or write guard,
// isolates the slave from AXI traffic (waiting for drain up to DrainTimeout
// cycles), holds the slave in reset for RstCycles cycles, then pulses
// reset_clear_o for two cycles so both guards drop their latched requests.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : guard_reset_sequencer_if.slave (request/status bundle)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for an enabled read/write reset request
// ISOLATE | new traffic blocked, waiting for isolated_i or drain timeout
// RESET   | slave held in reset for RstCycles cycles
// CLEAR   | 2-cycle reset_clear_o pulse to both guards
module guard_reset_sequencer #(
  parameter int RstCycles    = 16,
  parameter int DrainTimeout = 256,
  parameter int CntWidth     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  guard_reset_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_RESET   = 2'd2,
    ST_CLEAR   = 2'd3
  } state_e;

  localparam logic [15:0] DrainLast = 16'(DrainTimeout - 1);
  localparam logic [15:0] RstLast   = 16'(RstCycles - 1);

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          cause_q, cause_d;
  logic                dto_q, dto_d;
  logic                irq_q, irq_d;
  logic [CntWidth-1:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      dto_q   <= 1'b0;
      irq_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      dto_q   <= dto_d;
      irq_q   <= irq_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    dto_d   = dto_q;
    irq_d   = irq_q;
    rcnt_d  = rcnt_q;

    // Clear first so that a set later in this block wins.
    if (bus.irq_clr_i) irq_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable_i && (bus.rd_reset_req_i || bus.wr_reset_req_i)) begin
          state_d = ST_ISOLATE;
          cause_d = {bus.wr_reset_req_i, bus.rd_reset_req_i};
          cnt_d   = '0;
          dto_d   = 1'b0;
          irq_d   = 1'b1;
        end
      end
      ST_ISOLATE: begin
        if (bus.isolated_i || (cnt_q == DrainLast)) begin
          state_d = ST_RESET;
          cnt_d   = '0;
          if (!bus.isolated_i) dto_d = 1'b1;
          if (rcnt_q != '1) rcnt_d = rcnt_q + CntWidth'(1);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESET: begin
        if (cnt_q == RstLast) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == 16'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Decoded from the registered state only; async reset clears them at once.
  assign bus.isolate_o       = (state_q != ST_IDLE);
  assign bus.busy_o          = (state_q != ST_IDLE);
  assign bus.slv_rst_o       = (state_q == ST_RESET);
  assign bus.reset_clear_o   = (state_q == ST_CLEAR);
  assign bus.irq_o           = irq_q;
  assign bus.cause_o         = cause_q;
  assign bus.drain_timeout_o = dto_q;
  assign bus.reset_count_o   = rcnt_q;

endmodule

// File: tb/tb_guard_reset_sequencer.sv
module tb_guard_reset_sequencer;
  localparam int RstCycles    = 4;
  localparam int DrainTimeout = 8;
  localparam int CntWidth     = 2;

  logic clk_i;
  logic rst_i;
  int   chk_cnt;
  int   pass_cnt;

  guard_reset_sequencer_if #(.CntWidth(CntWidth)) gif ();

  guard_reset_sequencer #(
    .RstCycles   (RstCycles),
    .DrainTimeout(DrainTimeout),
    .CntWidth    (CntWidth)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (gif.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Count phase lengths of a running sequence, sampling the current cycle
  // first. isolated_i is raised once iso_delay ISOLATE cycles were seen
  // (0 = never). Returns when busy_o falls or the cycle budget runs out.
  task automatic wait_done(input int iso_delay, output int n_iso, output int n_rst,
                           output int n_clr, output bit timed_out);
    n_iso = 0; n_rst = 0; n_clr = 0; timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!gif.busy_o) begin
        timed_out = 1'b0;
        break;
      end
      if (gif.slv_rst_o) n_rst++;
      else if (gif.reset_clear_o) n_clr++;
      else if (gif.isolate_o) n_iso++;
      if (iso_delay != 0 && n_iso == iso_delay && n_rst == 0) gif.isolated_i = 1'b1;
      tick();
    end
    gif.isolated_i = 1'b0;
  endtask

  task automatic run_seq(input logic rd, input logic wr, input int iso_delay,
                         output logic first_iso, output int n_iso, output int n_rst,
                         output int n_clr, output bit timed_out);
    gif.enable_i       = 1'b1;
    gif.rd_reset_req_i = rd;
    gif.wr_reset_req_i = wr;
    tick();
    first_iso = gif.isolate_o;
    gif.rd_reset_req_i = 1'b0;
    gif.wr_reset_req_i = 1'b0;
    wait_done(iso_delay, n_iso, n_rst, n_clr, timed_out);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    gif.enable_i = 1'b0; gif.rd_reset_req_i = 1'b0; gif.wr_reset_req_i = 1'b0;
    gif.isolated_i = 1'b0; gif.irq_clr_i = 1'b0;
    tick(); tick();
    chk_cnt++;
    if ({gif.isolate_o, gif.slv_rst_o, gif.reset_clear_o, gif.busy_o, gif.irq_o,
         gif.drain_timeout_o} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {gif.isolate_o, gif.slv_rst_o,
               gif.reset_clear_o, gif.busy_o, gif.irq_o, gif.drain_timeout_o});
    else pass_cnt++;
    chk_cnt++;
    if (gif.cause_o !== 2'b00 || gif.reset_count_o !== 2'd0)
      $display("FAIL reset_regs: cause %b count %0d want 00/0", gif.cause_o, gif.reset_count_o);
    else pass_cnt++;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_read();
    logic fi; int ni, nr, nc; bit to;
    run_seq(1'b1, 1'b0, 2, fi, ni, nr, nc, to);
    chk_cnt++;
    if (to || fi !== 1'b1 || ni != 2)
      $display("FAIL read_isolate: timeout %0d first %b iso %0d want 0/1/2", to, fi, ni);
    else pass_cnt++;
    chk_cnt++;
    if (nr != 4 || nc != 2) $display("FAIL read_phases: rst %0d clr %0d want 4/2", nr, nc);
    else pass_cnt++;
    chk_cnt++;
    if ({gif.busy_o, gif.cause_o, gif.reset_count_o, gif.drain_timeout_o, gif.irq_o} !== 7'b0_01_01_0_1)
      $display("FAIL read_status: got %b want 0010101", {gif.busy_o, gif.cause_o,
               gif.reset_count_o, gif.drain_timeout_o, gif.irq_o});
    else pass_cnt++;
  endtask

  task automatic test_write_drain();
    logic fi; int ni, nr, nc; bit to;
    run_seq(1'b0, 1'b1, 0, fi, ni, nr, nc, to);
    chk_cnt++;
    if (to || ni != 8 || nr != 4)
      $display("FAIL drain_len: timeout %0d iso %0d rst %0d want 0/8/4", to, ni, nr);
    else pass_cnt++;
    chk_cnt++;
    if (gif.drain_timeout_o !== 1'b1 || gif.cause_o !== 2'b10 || gif.reset_count_o !== 2'd2)
      $display("FAIL drain_status: dto %b cause %b count %0d want 1/10/2",
               gif.drain_timeout_o, gif.cause_o, gif.reset_count_o);
    else pass_cnt++;
  endtask

  task automatic test_both();
    logic fi; int ni, nr, nc; bit to;
    run_seq(1'b1, 1'b1, 1, fi, ni, nr, nc, to);
    repeat (3) tick();
    chk_cnt++;
    if (to || nr != 4 || gif.busy_o !== 1'b0 || gif.cause_o !== 2'b11 ||
        gif.reset_count_o !== 2'd3 || gif.drain_timeout_o !== 1'b0)
      $display("FAIL both: timeout %0d rst %0d busy %b cause %b count %0d dto %b want 0/4/0/11/3/0",
               to, nr, gif.busy_o, gif.cause_o, gif.reset_count_o, gif.drain_timeout_o);
    else pass_cnt++;
    gif.irq_clr_i = 1'b1;
    tick();
    gif.irq_clr_i = 1'b0;
    chk_cnt++;
    if (gif.irq_o !== 1'b0) $display("FAIL irq_clear: got %b want 0", gif.irq_o);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    bit saw_clear;
    gif.enable_i = 1'b1; gif.rd_reset_req_i = 1'b1;
    tick();
    gif.rd_reset_req_i = 1'b0; gif.isolated_i = 1'b1;
    tick();
    gif.isolated_i = 1'b0;
    tick();
    chk_cnt++;
    if (gif.slv_rst_o !== 1'b1) $display("FAIL abort_setup: slv_rst %b want 1", gif.slv_rst_o);
    else pass_cnt++;
    #2 rst_i = 1'b1;
    #1;
    chk_cnt++;
    if ({gif.isolate_o, gif.slv_rst_o, gif.reset_clear_o, gif.busy_o, gif.irq_o,
         gif.drain_timeout_o, gif.cause_o, gif.reset_count_o} !== 10'b0)
      $display("FAIL abort_async: got %b want 0000000000", {gif.isolate_o, gif.slv_rst_o,
               gif.reset_clear_o, gif.busy_o, gif.irq_o, gif.drain_timeout_o,
               gif.cause_o, gif.reset_count_o});
    else pass_cnt++;
    #1 rst_i = 1'b0;
    saw_clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gif.reset_clear_o || gif.busy_o) saw_clear = 1'b1;
    end
    chk_cnt++;
    if (saw_clear) $display("FAIL abort_no_clear: activity seen after reset, want none");
    else pass_cnt++;
  endtask

  task automatic test_enable();
    bit moved; int ni, nr, nc; bit to;
    gif.enable_i = 1'b0; gif.rd_reset_req_i = 1'b1;
    moved = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gif.busy_o || gif.irq_o) moved = 1'b1;
    end
    chk_cnt++;
    if (moved) $display("FAIL enable_low: sequence started with enable_i=0, want idle");
    else pass_cnt++;
    gif.enable_i = 1'b1;
    tick();
    gif.rd_reset_req_i = 1'b0;
    chk_cnt++;
    if (gif.busy_o !== 1'b1 || gif.isolate_o !== 1'b1)
      $display("FAIL enable_start: busy %b isolate %b want 1/1", gif.busy_o, gif.isolate_o);
    else pass_cnt++;
    wait_done(1, ni, nr, nc, to);
    chk_cnt++;
    if (to || gif.reset_count_o !== 2'd1)
      $display("FAIL enable_done: timeout %0d count %0d want 0/1", to, gif.reset_count_o);
    else pass_cnt++;
  endtask

  task automatic test_irq_priority();
    int ni, nr, nc; bit to;
    gif.irq_clr_i = 1'b1;
    tick();
    chk_cnt++;
    if (gif.irq_o !== 1'b0) $display("FAIL irq_pre_clear: got %b want 0", gif.irq_o);
    else pass_cnt++;
    gif.enable_i = 1'b1; gif.wr_reset_req_i = 1'b1;
    tick();
    gif.wr_reset_req_i = 1'b0;
    chk_cnt++;
    if (gif.irq_o !== 1'b1 || gif.busy_o !== 1'b1)
      $display("FAIL irq_set_wins: irq %b busy %b want 1/1", gif.irq_o, gif.busy_o);
    else pass_cnt++;
    tick();
    gif.irq_clr_i = 1'b0;
    chk_cnt++;
    if (gif.irq_o !== 1'b0) $display("FAIL irq_clear_mid: got %b want 0", gif.irq_o);
    else pass_cnt++;
    wait_done(1, ni, nr, nc, to);
    chk_cnt++;
    if (to || gif.reset_count_o !== 2'd2 || gif.cause_o !== 2'b10)
      $display("FAIL irq_seq_done: timeout %0d count %0d cause %b want 0/2/10",
               to, gif.reset_count_o, gif.cause_o);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic fi; int ni, nr, nc; bit to;
    run_seq(1'b1, 1'b0, 1, fi, ni, nr, nc, to);
    chk_cnt++;
    if (to || gif.reset_count_o !== 2'd3)
      $display("FAIL sat_third: timeout %0d count %0d want 0/3", to, gif.reset_count_o);
    else pass_cnt++;
    run_seq(1'b0, 1'b1, 1, fi, ni, nr, nc, to);
    chk_cnt++;
    if (to || gif.reset_count_o !== 2'd3)
      $display("FAIL sat_fourth: timeout %0d count %0d want 0/3", to, gif.reset_count_o);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_read();
    test_write_drain();
    test_both();
    test_abort();
    test_enable();
    test_irq_priority();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
